// File: rtl/mix_fold_pkg.sv
// Shared types, constants and helpers for the mix_fold_digest block.
package mix_fold_pkg;

  localparam int LANES  = 8;
  localparam int WORD_W = 32;
  localparam int VEC_W  = LANES * WORD_W;

  localparam logic [WORD_W-1:0] FOLD_K_DEFAULT = 32'h9E3779B9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FOLD = 2'd1,
    EMIT = 2'd2
  } state_t;

  // One mixer state vector, lane 0 in the least significant word.
  typedef logic [LANES-1:0][WORD_W-1:0] vec_t;

  // Rotate a word left by five bit positions.
  function automatic logic [WORD_W-1:0] rotl5(input logic [WORD_W-1:0] x);
    return {x[WORD_W-6:0], x[WORD_W-1:WORD_W-5]};
  endfunction

endpackage

// File: rtl/mix_fold_digest_if.sv
// Vector-in / digest-out handshake bundle for mix_fold_digest.
// With MIX_FOLD_STATS_EN defined the bundle also carries stall_cycles.
interface mix_fold_digest_if;
  import mix_fold_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [VEC_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_digest;
  logic [15:0]      out_frame;
`ifdef MIX_FOLD_STATS_EN
  logic [31:0]      stall_cycles;
`endif

  // Upstream producer / downstream consumer side.
  modport master (
`ifdef MIX_FOLD_STATS_EN
    input  stall_cycles,
`endif
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_digest, out_frame
  );

  // Digest engine side.
  modport slave (
`ifdef MIX_FOLD_STATS_EN
    output stall_cycles,
`endif
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_digest, out_frame
  );

endinterface

// File: rtl/mix_fold_fifo.sv
// DEPTH-entry vector FIFO; full/empty decode from a registered occupancy count,
// so full never depends on the same-cycle pop.
module mix_fold_fifo
  import mix_fold_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  vec_t wdata,
  output vec_t rdata,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  vec_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == {CW{1'b0}});
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; push+pop together keeps the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      count <= count + CNT_ONE;
      else if (!do_push && do_pop) count <= count - CNT_ONE;
    end
  end

  // Storage write; contents need no reset because count guards every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mix_fold_digest.sv
// Folds queued 8x32 mixer vectors, one word per cycle, into a 32-bit digest
// emitted every FRAME vectors. Optional feature macro: MIX_FOLD_STATS_EN
// (adds a saturating stall_cycles counter on the interface).
module mix_fold_digest
  import mix_fold_pkg::*;
#(
  parameter int                DEPTH  = 4,
  parameter int                FRAME  = 16,
  parameter logic [WORD_W-1:0] FOLD_K = FOLD_K_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  mix_fold_digest_if.slave bus
);

  localparam logic [31:0] FRAME_LAST = 32'(FRAME - 1);

  state_t      state;
  state_t      state_next;
  logic        pop;
  logic        fold_en;
  logic        emit_done;
  logic        fifo_full;
  logic        fifo_empty;
  vec_t        head;
  vec_t        vec;
  logic [2:0]  idx;
  logic [31:0] vec_count;
  logic [31:0] acc;
  logic [15:0] frame_cnt;
  logic        last_word;
  logic        frame_done;

  mix_fold_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.in_valid),
    .pop   (pop),
    .wdata (bus.in_data),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign last_word      = (idx == 3'd7);
  assign frame_done     = last_word && (vec_count == FRAME_LAST);
  assign bus.in_ready   = !fifo_full;
  assign bus.out_valid  = (state == EMIT);
  assign bus.out_digest = acc;
  assign bus.out_frame  = frame_cnt;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and per-cycle controls; the last fold chains straight into the next vector.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    fold_en    = 1'b0;
    emit_done  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = FOLD;
        end else begin
          state_next = IDLE;
        end
      end
      FOLD: begin
        fold_en = 1'b1;
        if (!last_word) begin
          state_next = FOLD;
        end else if (frame_done) begin
          state_next = EMIT;
        end else if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = FOLD;
        end else begin
          state_next = IDLE;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          emit_done  = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = EMIT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Fold datapath: vector capture, lane index, accumulator, vector and frame counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec       <= '0;
      idx       <= 3'd0;
      acc       <= 32'd0;
      vec_count <= 32'd0;
      frame_cnt <= 16'd0;
    end else begin
      if (pop) begin
        vec <= head;
        idx <= 3'd0;
      end else if (fold_en) begin
        idx <= idx + 3'd1;
      end
      if (emit_done)    acc <= 32'd0;
      else if (fold_en) acc <= rotl5(acc) + (vec[idx] ^ FOLD_K);
      if (emit_done)                 vec_count <= 32'd0;
      else if (fold_en && last_word) vec_count <= vec_count + 32'd1;
      if (emit_done) frame_cnt <= frame_cnt + 16'd1;
    end
  end

`ifdef MIX_FOLD_STATS_EN
  logic [31:0] stall;

  assign bus.stall_cycles = stall;

  // Count cycles where either side is held off, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall <= 32'd0;
    end else if (((bus.in_valid && !fifo_full) == 1'b0 && bus.in_valid) ||
                 ((state == EMIT) && !bus.out_ready)) begin
      if (stall != 32'hFFFFFFFF) stall <= stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mix_fold_digest.sv
// Randomized self-checking bench for mix_fold_digest against a frame-level
// digest model (one FRAME=1 instance for directed cases, one FRAME=16 instance).
module tb_mix_fold_digest;
  import mix_fold_pkg::*;

  localparam logic [31:0] K = 32'h9E3779B9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mix_fold_digest_if bus1 ();
  mix_fold_digest_if bus16 ();

  mix_fold_digest #(.DEPTH(4), .FRAME(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1.slave));
  mix_fold_digest #(.DEPTH(4), .FRAME(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

  bit               sel;        // 0: FRAME=1 instance, 1: FRAME=16 instance
  bit               drv_valid;
  bit               drv_ready;
  logic [VEC_W-1:0] drv_data;

  assign bus1.in_valid   = drv_valid && !sel;
  assign bus1.in_data    = drv_data;
  assign bus1.out_ready  = drv_ready && !sel;
  assign bus16.in_valid  = drv_valid && sel;
  assign bus16.in_data   = drv_data;
  assign bus16.out_ready = drv_ready && sel;

  logic        obs_in_ready, obs_out_valid;
  logic [31:0] obs_out_digest;
  logic [15:0] obs_out_frame;
  assign obs_in_ready   = sel ? bus16.in_ready   : bus1.in_ready;
  assign obs_out_valid  = sel ? bus16.out_valid  : bus1.out_valid;
  assign obs_out_digest = sel ? bus16.out_digest : bus1.out_digest;
  assign obs_out_frame  = sel ? bus16.out_frame  : bus1.out_frame;
`ifdef MIX_FOLD_STATS_EN
  logic [31:0] obs_stall;
  assign obs_stall = sel ? bus16.stall_cycles : bus1.stall_cycles;
`endif

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model state.
  logic [31:0] exp_q[$];
  logic [31:0] m_acc;
  int          m_cnt;
  logic [15:0] m_frames;
  int          m_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_fold(input logic [31:0] a, input logic [31:0] w);
    logic [31:0] r;
    r = (a << 5) | (a >> 27);
    return r + (w ^ K);
  endfunction

  function automatic logic [VEC_W-1:0] rand_vec();
    logic [VEC_W-1:0] v;
    for (int i = 0; i < LANES; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  task automatic model_push(input logic [VEC_W-1:0] d);
    int flen;
    flen = sel ? 16 : 1;
    for (int i = 0; i < LANES; i++) m_acc = model_fold(m_acc, d[32*i +: 32]);
    m_cnt++;
    if (m_cnt == flen) begin
      exp_q.push_back(m_acc);
      m_acc = 32'd0;
      m_cnt = 0;
    end
  endtask

  // One cycle: drive at the negedge, check outputs, record the handshakes the next posedge takes.
  task automatic step(input bit v, input logic [VEC_W-1:0] d, input bit r);
    drv_valid = v;
    drv_data  = d;
    drv_ready = r;
    if (obs_out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 32'd1, 32'd0);
      end else if (r) begin
        check("digest", obs_out_digest, exp_q[0]);
        check("frame_at_hs", {16'd0, obs_out_frame}, {16'd0, m_frames});
        void'(exp_q.pop_front());
        m_frames++;
      end else begin
        check("digest_hold", obs_out_digest, exp_q[0]);
      end
    end
    if ((v && !obs_in_ready) || (obs_out_valid && !r)) m_stall++;
    if (v && obs_in_ready) model_push(d);
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    drv_valid = 1'b0;
    drv_ready = 1'b0;
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_acc = 32'd0;
    m_cnt = 0;
    m_frames = 16'd0;
    m_stall = 0;
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 300 && exp_q.size() > 0; c++) step(1'b0, '0, 1'b1);
    check(tag, exp_q.size(), 32'd0);
    repeat (12) step(1'b0, '0, 1'b1);
    check("idle_after_drain", {31'd0, obs_out_valid}, 32'd0);
  endtask

  task automatic single_vector(input logic [VEC_W-1:0] d, input logic [31:0] want, input string tag);
    int lat;
    step(1'b1, d, 1'b0);
    lat = 1;
    while (!obs_out_valid && lat < 40) begin
      step(1'b0, '0, 1'b0);
      lat++;
    end
    check("latency", lat, 32'd10);
    check(tag, obs_out_digest, want);
    step(1'b0, '0, 1'b1);
    check("frame_after", {16'd0, obs_out_frame}, 32'd1);
  endtask

  initial begin
    logic [VEC_W-1:0] d;
    int acc_n;
    int cyc;
    bit v;
    bit fire;

    sel = 1'b0;
    drv_valid = 1'b0;
    drv_ready = 1'b0;
    drv_data = '0;

    // Reset values on both instances.
    do_reset(2);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("rst_in_ready",  {31'd0, obs_in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, obs_out_valid}, 32'd0);
      check("rst_digest",    obs_out_digest, 32'd0);
      check("rst_frame",     {16'd0, obs_out_frame}, 32'd0);
`ifdef MIX_FOLD_STATS_EN
      check("rst_stall",     obs_stall, 32'd0);
`endif
    end
    @(negedge clk);

    // Every lane equal to the fold constant folds to zero.
    sel = 1'b0;
    do_reset(2);
    for (int i = 0; i < LANES; i++) d[32*i +: 32] = K;
    single_vector(d, 32'h00000000, "zero_digest");

    // A single low bit in lane 0 ends up rotated left 35 -> 3 places.
    do_reset(2);
    d[31:0] = 32'h9E3779B8;
    single_vector(d, 32'h00000008, "rot_digest");

    // Backpressure: output stalled, six vectors offered back-to-back.
    do_reset(2);
    acc_n = 0;
    d = rand_vec();
    for (int c = 0; c < 40; c++) begin
      if (c == 30) begin
        check("bp_accepted", acc_n, 32'd5);
        check("bp_in_ready", {31'd0, obs_in_ready}, 32'd0);
      end
      fire = obs_in_ready && (acc_n < 6);
      step(acc_n < 6, d, 1'b0);
      if (fire) begin
        acc_n++;
        d = rand_vec();
      end
    end
    for (int c = 0; c < 100 && acc_n < 6; c++) begin
      fire = obs_in_ready;
      step(1'b1, d, 1'b1);
      if (fire) begin
        acc_n++;
        d = rand_vec();
      end
    end
    check("bp_all_pushed", acc_n, 32'd6);
    drain("bp_drain");
`ifdef MIX_FOLD_STATS_EN
    check("bp_stall_cycles", obs_stall, m_stall);
`endif

    // Reset a few cycles into a fold; the next frame starts from scratch.
    sel = 1'b1;
    do_reset(2);
    for (int i = 0; i < 3; i++) step(1'b1, rand_vec(), 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    do_reset(3);
    acc_n = 0;
    for (int c = 0; c < 400 && acc_n < 16; c++) begin
      fire = obs_in_ready;
      step(1'b1, rand_vec(), 1'b1);
      if (fire) acc_n++;
    end
    drain("rf_drain");
    check("rf_frame_after", {16'd0, obs_out_frame}, 32'd1);

    // Random traffic on the FRAME=16 instance.
    do_reset(2);
    acc_n = 0;
    cyc = 0;
    while (acc_n < 1000 && cyc < 30000) begin
      v = ($urandom_range(0, 3) != 0);
      fire = v && obs_in_ready;
      step(v, rand_vec(), $urandom_range(0, 2) != 0);
      if (fire) acc_n++;
      cyc++;
    end
    check("rand_accepted", acc_n, 32'd1000);
    drain("rand_drain");
    check("rand_frame_count", {16'd0, obs_out_frame}, {16'd0, m_frames});
`ifdef MIX_FOLD_STATS_EN
    check("rand_stall_cycles", obs_stall, m_stall);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/mix_fold_digest.md
Name: mix_fold_digest

Overview:
- Downstream consumer of the eight-lane 32-bit mixing stage.
- Accepts one 8x32 state vector per handshake and buffers it in a small FIFO.
- Serially folds the eight words, one word per cycle, into a 32-bit running digest.
- After FRAME vectors it emits the digest on a valid/ready output; simulator benchmarks use this digest as a compact check of the mixer state.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
FRAME, 16, vectors folded per emitted digest (>=1)
FOLD_K, 32'h9E3779B9, per-word XOR constant

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  synchronous active-high reset
in_valid  in  1  upstream vector valid
in_ready  out  1  FIFO can accept (not full)
in_data  in  256  lane i at [32*i+31:32*i], lane 0 = o0
out_valid  out  1  digest valid
out_ready  in  1  downstream accepts digest
out_digest  out  32  folded digest
out_frame  out  16  count of digests emitted, wraps mod 2^16

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset values: in_ready=1, out_valid=0, out_digest=0, out_frame=0, acc=0, FIFO empty, FSM=IDLE, lane idx=0, vec count=0.
- Reset asserted mid-fold or mid-emit discards all buffered vectors and any partial digest.
- Input handshake: push when in_valid && in_ready.
  - in_ready = (fifo_count != DEPTH), driven from registered count.
  - When the FIFO is full, a simultaneous pop in the same cycle does NOT raise in_ready; there is no combinational ready path.
  - Push and pop in the same cycle leave the count unchanged.
- FSM states:
  - IDLE: when the FIFO is non-empty, pop the head into a vector register, set idx=0, go to FOLD.
  - FOLD: each cycle acc <= {acc[26:0],acc[31:27]} + (lane[idx] ^ FOLD_K), modulo 2^32; idx++.
    - At idx==7, vec count++.
    - If vec count reaches FRAME, go to EMIT.
    - Otherwise, if the FIFO is non-empty, pop the next vector and stay in FOLD with idx=0 (no bubble); else go to IDLE.
  - EMIT: out_valid=1, out_digest=acc, held stable until out_ready.
    - On the handshake cycle: acc<=0, vec count<=0, out_frame++, go to IDLE.
    - The FIFO keeps accepting input during EMIT.
- Latency: a vector pushed at cycle t into an empty FIFO in IDLE is popped at t+1 and folded in cycles t+2..t+9. For FRAME=1, out_valid rises at t+10.
- Throughput: 8 cycles per vector. Upstream stalls via in_ready once DEPTH vectors are queued.
- out_frame wraps from 16'hFFFF to 0.
- in_data is ignored when in_valid=0. Values are unsigned.

Optional Feature:
- Macro: MIX_FOLD_STATS_EN.
- Defined: adds output stall_cycles[31:0] (reset 0). It increments, saturating at 32'hFFFFFFFF, on each cycle with in_valid && !in_ready or with out_valid && !out_ready.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package mix_fold_pkg holds:
  - LANES=8 and WORD_W=32
  - the FSM state enum {IDLE, FOLD, EMIT}
  - FOLD_K default
  - a rotl5 function
- One natural sub-module, mix_fold_fifo: DEPTH x 256 synchronous FIFO with push/pop, full/empty and registered count.

Test Plan:
- Reset check: assert rst for 2 cycles, then check all outputs at reset values and in_ready=1.
- Zero fold, FRAME=1: one vector with every lane = 32'h9E3779B9 -> out_digest=32'h00000000, out_valid at push+10 cycles, out_frame=1 after handshake.
- Rotation, FRAME=1: lane0=32'h9E3779B8, lanes1-7=32'h9E3779B9 -> out_digest=32'h00000008.
- Backpressure, DEPTH=4: hold out_ready=0 and push 6 vectors back-to-back -> in_ready drops after the 4th queued vector. With stats defined, stall_cycles increments. No vector is lost; release out_ready and check all digests match the model.
- Reset during fold: assert rst 3 cycles into a FOLD -> next frame's digest equals a fresh model with no carry-over, and out_frame restarts at 0.
- Random traffic, FRAME=16: 1000 random vectors with random in_valid/out_ready -> every digest and out_frame matches the reference model, and out_digest stays stable while out_valid && !out_ready.
